// File: rtl/mem_dport_ctrl.sv
// ---------------------------------------------------------------------------
// mem_dport_ctrl
// MEM-stage data-port controller for an RV32I pipeline. It decodes the load or
// store coming out of EX/MEM and issues it to a single-ported data memory. The
// request is held until dmem_resp arrives, and the pipeline is stalled while
// the access is outstanding. Store data is lane-aligned and byte enables are
// generated. Load data is extracted and sign/zero-extended. Misaligned and
// illegal accesses are reported to the RVFI monitor and are never issued.
// ---------------------------------------------------------------------------
module mem_dport_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_address,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_byte_enable,
    input  logic              dmem_resp,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic [3:0]        rmask,
    output logic [3:0]        wmask,
    output logic              misalign
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // funct3 legality. A simultaneous read and write is never legal.
    function automatic logic funct3_legal(input logic rd, input logic wr,
                                          input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (rd && wr) begin
            ok = 1'b0;
        end else if (rd) begin
            case (f3)
                3'd0, 3'd1, 3'd2, 3'd4, 3'd5: ok = 1'b1;
                default:                      ok = 1'b0;
            endcase
        end else if (wr) begin
            case (f3)
                3'd0, 3'd1, 3'd2: ok = 1'b1;
                default:          ok = 1'b0;
            endcase
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // Natural alignment check. size: 0 byte, 1 half, 2 word.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            2'd0:    ok = 1'b1;
            2'd1:    ok = ~off[0];
            2'd2:    ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte-lane mask of the access within the 32-bit word.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'b0001 << off;
            2'd1:    m = 4'b0011 << {off[1], 1'b0};
            2'd2:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Pull the addressed byte/half down to bit 0 and extend it.
    function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] raw);
        logic [31:0] sh;
        logic [31:0] res;
        sh = raw >> {off, 3'b000};
        case (f3)
            3'd0:    res = {{24{sh[7]}}, sh[7:0]};
            3'd1:    res = {{16{sh[15]}}, sh[15:0]};
            3'd2:    res = raw;
            3'd4:    res = {24'h000000, sh[7:0]};
            3'd5:    res = {16'h0000, sh[15:0]};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    state_t      state_r;
    state_t      state_next_s;
    logic [1:0]  offset_s;
    logic [1:0]  size_s;
    logic        any_req_s;
    logic        legal_s;
    logic        aligned_s;
    logic        active_s;
    logic        take_resp_s;
    logic [3:0]  lane_mask_s;
    logic [31:0] load_ext_s;

    logic        dmem_read_s;
    logic        dmem_write_s;
    logic        stall_s;
    logic [3:0]  byte_enable_s;
    logic        misalign_s;

    assign offset_s    = req_addr[1:0];
    assign size_s      = req_funct3[1:0];
    assign any_req_s   = req_read | req_write;
    assign legal_s     = funct3_legal(req_read, req_write, req_funct3);
    assign aligned_s   = is_aligned(size_s, offset_s);
    assign active_s    = any_req_s & legal_s & aligned_s;
    assign lane_mask_s = lane_mask(size_s, offset_s);
    assign load_ext_s  = extract_load(req_funct3, offset_s, dmem_rdata);

    // A response is only meaningful while an access is on the bus.
    assign take_resp_s = dmem_resp &
                         (((state_r == ST_IDLE) & active_s) | (state_r == ST_BUSY));

    // The address and store data are pure functions of the held request.
    assign dmem_address = {req_addr[ADDR_W-1:2], 2'b00};
    assign dmem_wdata   = req_wdata << {offset_s, 3'b000};

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: zero-wait responses skip BUSY. DONE always returns to IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (active_s) begin
                    if (dmem_resp) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_BUSY;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (dmem_resp) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Strobes, stall and misalign. These are gated by rst_n so the memory
    // and the pipeline see them drop as soon as reset asserts.
    always_comb begin
        dmem_read_s   = 1'b0;
        dmem_write_s  = 1'b0;
        stall_s       = 1'b0;
        byte_enable_s = 4'b0000;
        misalign_s    = 1'b0;
        if (!rst_n) begin
            dmem_read_s   = 1'b0;
            dmem_write_s  = 1'b0;
            stall_s       = 1'b0;
            byte_enable_s = 4'b0000;
            misalign_s    = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (active_s) begin
                        dmem_read_s  = req_read;
                        dmem_write_s = req_write;
                        stall_s      = 1'b1;
                    end else begin
                        stall_s    = 1'b0;
                        misalign_s = any_req_s;
                    end
                end
                ST_BUSY: begin
                    dmem_read_s  = req_read;
                    dmem_write_s = req_write;
                    stall_s      = 1'b1;
                end
                ST_DONE: begin
                    stall_s = 1'b0;
                end
                default: begin
                    stall_s = 1'b0;
                end
            endcase
            if (dmem_write_s) begin
                byte_enable_s = lane_mask_s;
            end else begin
                byte_enable_s = 4'b0000;
            end
        end
    end

    assign dmem_read        = dmem_read_s;
    assign dmem_write       = dmem_write_s;
    assign stall            = stall_s;
    assign dmem_byte_enable = byte_enable_s;
    assign misalign         = misalign_s;

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------

    // Capture load result and monitor masks on the response. The mask of the
    // other direction is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_data <= '0;
            rmask     <= 4'b0000;
            wmask     <= 4'b0000;
        end else if (take_resp_s) begin
            if (req_read) begin
                load_data <= load_ext_s;
                rmask     <= lane_mask_s;
                wmask     <= 4'b0000;
            end else begin
                load_data <= load_data;
                rmask     <= 4'b0000;
                wmask     <= lane_mask_s;
            end
        end else begin
            load_data <= load_data;
            rmask     <= rmask;
            wmask     <= wmask;
        end
    end

endmodule

// File: tb/tb_mem_dport_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_dport_ctrl
// Self-checking bench for mem_dport_ctrl. A directed vector table covers the
// named load/store cases. Hand sequences cover reset and stray responses.
// Randomized accesses are then checked against a spec-level reference model.
// ---------------------------------------------------------------------------
module tb_mem_dport_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_read;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] load_data;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic        misalign;

    int n_total;
    int n_pass;

    // Expected contents of the result registers, tracked by the bench.
    logic [31:0] m_load;
    logic [3:0]  m_rmask;
    logic [3:0]  m_wmask;

    mem_dport_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_read         (req_read),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_funct3       (req_funct3),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .stall            (stall),
        .load_data        (load_data),
        .rmask            (rmask),
        .wmask            (wmask),
        .misalign         (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_n;
        logic        bad;
        logic [31:0] e_load;
        logic [31:0] e_wdata;
        logic [3:0]  e_rmask;
        logic [3:0]  e_wmask;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model. It applies the legality, size, lane and extension rules
    // with plain arithmetic.
    function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rdata, output logic ok,
                                  output logic [31:0] e_load, output logic [31:0] e_wdata,
                                  output logic [3:0] e_mask);
        int nb;
        int off;
        logic [31:0] lim;
        logic [31:0] val;
        nb  = 1 << int'(f3[1:0]);
        off = int'(addr[1:0]);
        if (rd && wr)  ok = 1'b0;
        else if (rd)   ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        else if (wr)   ok = (f3 inside {3'd0, 3'd1, 3'd2});
        else           ok = 1'b0;
        if ((int'(addr[2:0]) % nb) != 0) ok = 1'b0;
        e_mask  = 4'(((1 << nb) - 1) << off);
        e_wdata = wdata << (8 * off);
        lim     = (nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        val     = (rdata >> (8 * off)) & lim;
        if (!f3[2] && nb < 4 && val[8 * nb - 1]) val = val | ~lim;
        e_load  = val;
    endfunction

    // One legal access with a memory that answers after wait_n cycles.
    // Starts and ends one time unit after a rising edge.
    task automatic run_access(input string name, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int wait_n, input logic [31:0] e_load,
                              input logic [31:0] e_wdata, input logic [3:0] e_rmask,
                              input logic [3:0] e_wmask);
        int n_stall;
        int n_rd;
        int n_wr;
        logic [31:0] a0;
        logic [31:0] w0;
        logic [3:0]  be0;
        logic        mis0;
        n_stall = 0;
        n_rd = 0;
        n_wr = 0;
        a0 = 32'h0;
        w0 = 32'h0;
        be0 = 4'h0;
        mis0 = 1'b0;
        req_read   = rd;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        dmem_rdata = rdata;
        for (int k = 0; k <= wait_n; k++) begin
            dmem_resp = (k == wait_n);
            @(negedge clk);
            if (k == 0) begin
                a0   = dmem_address;
                w0   = dmem_wdata;
                be0  = dmem_byte_enable;
                mis0 = misalign;
            end
            if (stall)      n_stall++;
            if (dmem_read)  n_rd++;
            if (dmem_write) n_wr++;
            @(posedge clk);
            #1;
        end
        dmem_resp = 1'b0;
        @(negedge clk);
        chk({name, "_done_outs"}, {29'd0, dmem_read, dmem_write, stall}, 32'd0);
        chk({name, "_load_data"}, load_data, e_load);
        chk({name, "_rmask"}, {28'd0, rmask}, {28'd0, e_rmask});
        chk({name, "_wmask"}, {28'd0, wmask}, {28'd0, e_wmask});
        m_load  = e_load;
        m_rmask = e_rmask;
        m_wmask = e_wmask;
        @(posedge clk);
        #1;
        req_read  = 1'b0;
        req_write = 1'b0;
        chk({name, "_stall_cycles"}, n_stall, wait_n + 1);
        chk({name, "_read_cycles"}, n_rd, rd ? wait_n + 1 : 0);
        chk({name, "_write_cycles"}, n_wr, wr ? wait_n + 1 : 0);
        chk({name, "_address"}, a0, addr & 32'hFFFF_FFFC);
        chk({name, "_misalign"}, {31'd0, mis0}, 32'd0);
        if (wr) begin
            chk({name, "_wdata"}, w0, e_wdata);
            chk({name, "_byte_en"}, {28'd0, be0}, {28'd0, e_wmask});
        end
    endtask

    // A misaligned or illegal request held for two cycles while the memory
    // pulses a stray response. Nothing may be issued or captured.
    task automatic run_bad(input string name, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] addr);
        req_read   = rd;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = 32'h1234_5678;
        dmem_rdata = 32'hA5A5_A5A5;
        dmem_resp  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk({name, "_misalign"}, {31'd0, misalign}, 32'd1);
            chk({name, "_no_strobe"}, {29'd0, dmem_read, dmem_write, stall}, 32'd0);
            @(posedge clk);
            #1;
        end
        dmem_resp = 1'b0;
        req_read  = 1'b0;
        req_write = 1'b0;
        @(negedge clk);
        chk({name, "_load_hold"}, load_data, m_load);
        chk({name, "_mask_hold"}, {24'd0, rmask, wmask}, {24'd0, m_rmask, m_wmask});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ok;
        logic [31:0] e_load;
        logic [31:0] e_wdata;
        logic [3:0]  e_mask;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          kind;

        n_total = 0;
        n_pass  = 0;
        m_load  = 32'h0;
        m_rmask = 4'h0;
        m_wmask = 4'h0;

        vecs[0]  = '{"lw",      1'b1, 1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 3, 1'b0, 32'hDEADBEEF, 32'h0,        4'hF, 4'h0};
        vecs[1]  = '{"lb",      1'b1, 1'b0, 3'd0, 32'h103, 32'h0,        32'h80FF1234, 1, 1'b0, 32'hFFFFFF80, 32'h0,        4'h8, 4'h0};
        vecs[2]  = '{"lbu",     1'b1, 1'b0, 3'd4, 32'h103, 32'h0,        32'h80FF1234, 0, 1'b0, 32'h00000080, 32'h0,        4'h8, 4'h0};
        vecs[3]  = '{"sh",      1'b0, 1'b1, 3'd1, 32'h202, 32'h0000ABCD, 32'hFFFFFFFF, 2, 1'b0, 32'h00000080, 32'hABCD0000, 4'h0, 4'hC};
        vecs[4]  = '{"lh",      1'b1, 1'b0, 3'd1, 32'h102, 32'h0,        32'h80FF1234, 0, 1'b0, 32'hFFFF80FF, 32'h0,        4'hC, 4'h0};
        vecs[5]  = '{"lhu",     1'b1, 1'b0, 3'd5, 32'h100, 32'h0,        32'h80FF1234, 1, 1'b0, 32'h00001234, 32'h0,        4'h3, 4'h0};
        vecs[6]  = '{"sb",      1'b0, 1'b1, 3'd0, 32'h101, 32'h00000055, 32'h0,        0, 1'b0, 32'h00001234, 32'h00005500, 4'h0, 4'h2};
        vecs[7]  = '{"sw",      1'b0, 1'b1, 3'd2, 32'h300, 32'hCAFEF00D, 32'h0,        4, 1'b0, 32'h00001234, 32'hCAFEF00D, 4'h0, 4'hF};
        vecs[8]  = '{"lw_mis",  1'b1, 1'b0, 3'd2, 32'h101, 32'h0,        32'h0,        0, 1'b1, 32'h0,        32'h0,        4'h0, 4'h0};
        vecs[9]  = '{"ld_f3_3", 1'b1, 1'b0, 3'd3, 32'h100, 32'h0,        32'h0,        0, 1'b1, 32'h0,        32'h0,        4'h0, 4'h0};
        vecs[10] = '{"lh_mis",  1'b1, 1'b0, 3'd1, 32'h101, 32'h0,        32'h0,        0, 1'b1, 32'h0,        32'h0,        4'h0, 4'h0};
        vecs[11] = '{"st_f3_4", 1'b0, 1'b1, 3'd4, 32'h100, 32'h0,        32'h0,        0, 1'b1, 32'h0,        32'h0,        4'h0, 4'h0};
        vecs[12] = '{"rd_wr",   1'b1, 1'b1, 3'd2, 32'h100, 32'h0,        32'h0,        0, 1'b1, 32'h0,        32'h0,        4'h0, 4'h0};
        vecs[13] = '{"lw_zero", 1'b1, 1'b0, 3'd2, 32'h004, 32'h0,        32'h13579BDF, 0, 1'b0, 32'h13579BDF, 32'h0,        4'hF, 4'h0};

        // Reset with a request present: everything must be quiet.
        rst_n      = 1'b0;
        req_read   = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        dmem_resp  = 1'b0;
        dmem_rdata = 32'h0;
        #7;
        chk("rst_outs", {28'd0, dmem_read, dmem_write, stall, misalign}, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_masks", {24'd0, rmask, wmask}, 32'd0);
        req_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table.
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].bad) begin
                run_bad(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr);
            end else begin
                run_access(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr,
                           vecs[i].wdata, vecs[i].rdata, vecs[i].wait_n, vecs[i].e_load,
                           vecs[i].e_wdata, vecs[i].e_rmask, vecs[i].e_wmask);
            end
        end

        // Stray response while idle with no request is ignored.
        dmem_rdata = 32'h5A5A_5A5A;
        dmem_resp  = 1'b1;
        @(negedge clk);
        chk("stray_resp_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        dmem_resp = 1'b0;
        @(negedge clk);
        chk("stray_resp_load", load_data, m_load);
        chk("stray_resp_masks", {24'd0, rmask, wmask}, {24'd0, m_rmask, m_wmask});
        @(posedge clk);
        #1;

        // Reset in the middle of a BUSY load: strobe and stall drop at once.
        req_read   = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h40;
        dmem_resp  = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("busy_before_rst", {30'd0, dmem_read, stall}, 32'd3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs", {29'd0, dmem_read, dmem_write, stall}, 32'd0);
        chk("rst_async_load", load_data, 32'd0);
        req_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_load  = 32'h0;
        m_rmask = 4'h0;
        m_wmask = 4'h0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_rst_idle", {31'd0, stall}, 32'd0);
        chk("post_rst_load", load_data, 32'd0);
        @(posedge clk);
        #1;
        run_access("post_rst_lw", 1'b1, 1'b0, 3'd2, 32'h80, 32'h0, 32'h0BADF00D, 0,
                   32'h0BADF00D, 32'h0, 4'hF, 4'h0);

        // Randomized accesses against the reference model.
        for (int i = 0; i < 150; i++) begin
            kind  = int'($urandom_range(0, 9));
            addr  = $urandom;
            wdata = $urandom;
            rdata = $urandom;
            rd    = (kind <= 3) || (kind == 8);
            wr    = (kind >= 4 && kind <= 8);
            if (kind <= 3) f3 = 3'($urandom_range(0, 7));
            else           f3 = 3'($urandom_range(0, 3));
            if (kind == 9) begin
                @(negedge clk);
                chk("rand_idle", {30'd0, stall, misalign}, 32'd0);
                @(posedge clk);
                #1;
            end else begin
                model(rd, wr, f3, addr, wdata, rdata, ok, e_load, e_wdata, e_mask);
                if (!ok) begin
                    run_bad("rand_bad", rd, wr, f3, addr);
                end else if (rd) begin
                    run_access("rand_ld", rd, wr, f3, addr, wdata, rdata,
                               int'($urandom_range(0, 4)), e_load, e_wdata, e_mask, 4'h0);
                end else begin
                    run_access("rand_st", rd, wr, f3, addr, wdata, rdata,
                               int'($urandom_range(0, 4)), m_load, e_wdata, 4'h0, e_mask);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
